// File: rtl/period_accumulator.sv
// Integrate-and-dump: sums every sample over a sync-aligned window of PERIOD clocks
// and emits one full-precision signed sum per window with a single-cycle strobe.
module period_accumulator #(
    parameter  int WIDTH       = 8,
    parameter  int PERIOD      = 128,
    localparam int PERIOD_BITS = $clog2(PERIOD)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                sync,
    input  logic signed [WIDTH-1:0]             din,
    output logic signed [WIDTH+PERIOD_BITS-1:0] dout,
    output logic                                dout_valid,
    output logic                                sync_out
);

    localparam int SUM_W = WIDTH + PERIOD_BITS;
    localparam logic [PERIOD_BITS-1:0] LAST = PERIOD_BITS'(PERIOD - 1);

    logic                    armed;
    logic                    first_after_sync;
    logic [PERIOD_BITS-1:0]  ctr;
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] din_ext;
    logic signed [SUM_W-1:0] sum;
    logic                    last;

    function automatic logic signed [SUM_W-1:0] sign_extend(input logic signed [WIDTH-1:0] x);
        return SUM_W'(x);
    endfunction

    assign din_ext = sign_extend(din);
    assign sum     = acc + din_ext;
    assign last    = (ctr == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed            <= 1'b0;
            first_after_sync <= 1'b0;
            ctr              <= '0;
            acc              <= '0;
            dout             <= '0;
            dout_valid       <= 1'b0;
            sync_out         <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_out   <= 1'b0;

            // A window completing on a sync cycle is still emitted, but its
            // sync_out is deferred to the first window started by that sync.
            if (armed && last) begin
                dout       <= sum;
                dout_valid <= 1'b1;
                sync_out   <= first_after_sync && !sync;
            end

            if (sync) begin
                armed            <= 1'b1;
                ctr              <= '0;
                first_after_sync <= 1'b1;
            end else if (armed) begin
                acc <= (ctr == '0) ? din_ext : sum;
                ctr <= ctr + PERIOD_BITS'(1);
                if (last) begin
                    first_after_sync <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_period_accumulator.sv
// Bench for period_accumulator: directed PERIOD=4 scenarios plus randomized PERIOD=128
// stress, both checked every cycle against a sample-list reference model.
module tb_period_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              sync4 = 1'b0;
    logic signed [7:0] din4 = '0;
    logic signed [9:0] dout4;
    logic              dv4, so4;

    logic               sync128 = 1'b0;
    logic signed [7:0]  din128 = '0;
    logic signed [14:0] dout128;
    logic               dv128, so128;

    period_accumulator #(.WIDTH(8), .PERIOD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sync(sync4), .din(din4),
        .dout(dout4), .dout_valid(dv4), .sync_out(so4)
    );

    period_accumulator #(.WIDTH(8), .PERIOD(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .sync(sync128), .din(din128),
        .dout(dout128), .dout_valid(dv128), .sync_out(so128)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: each instance keeps the list of samples in the current window.
    int  p_m [2] = '{4, 128};
    int  win [2][128];
    int  wcnt [2];
    bit  marm [2];
    bit  mpend [2];
    int  e_dout [2];
    bit  e_v [2];
    bit  e_so [2];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d required %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            marm[i] = 0; mpend[i] = 0; wcnt[i] = 0;
            e_dout[i] = 0; e_v[i] = 0; e_so[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit s, input int d);
        e_v[i] = 0;
        e_so[i] = 0;
        if (marm[i]) begin
            win[i][wcnt[i]] = d;
            wcnt[i]++;
            if (wcnt[i] == p_m[i]) begin
                int t = 0;
                for (int k = 0; k < p_m[i]; k++) t += win[i][k];
                e_dout[i] = t;
                e_v[i] = 1;
                e_so[i] = mpend[i] && !s;
                mpend[i] = 0;
                wcnt[i] = 0;
            end
        end
        if (s) begin
            marm[i] = 1;
            wcnt[i] = 0;
            mpend[i] = 1;
        end
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else begin
            model_step(0, sync4, din4);
            model_step(1, sync128, din128);
        end
        @(posedge clk);
        #1;
        cyc++;
        check("d4_dout", dout4, e_dout[0]);
        check("d4_valid", dv4, e_v[0]);
        check("d4_sync_out", so4, e_so[0]);
        check("d128_dout", dout128, e_dout[1]);
        check("d128_valid", dv128, e_v[1]);
        check("d128_sync_out", so128, e_so[1]);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic restart();
        rst_n = 0;
        model_reset();
        sync4 = 0; sync128 = 0; din4 = 0; din128 = 0;
        tick();
        tick();
        rst_n = 1;
        cyc = 0;
    endtask

    initial begin
        int s;
        int last_strobe;
        bit sync_seen;
        bit forced;
        int n_strobe;

        // Reset state and constant input
        restart();
        check("rst_dout", dout4, 0);
        check("rst_valid", dv4, 0);
        din4 = 1;
        run_to(10);
        check("pre_sync_valid", dv4, 0);
        sync4 = 1; tick(); sync4 = 0;
        run_to(15);
        check("const_v15", dv4, 1); check("const_d15", dout4, 4); check("const_so15", so4, 1);
        run_to(16);
        check("const_v16", dv4, 0); check("const_hold16", dout4, 4);
        run_to(19);
        check("const_v19", dv4, 1); check("const_d19", dout4, 4); check("const_so19", so4, 0);
        run_to(23);
        check("const_v23", dv4, 1); check("const_so23", so4, 0);

        // Negative full scale then ramp
        restart();
        din4 = -128;
        run_to(10);
        check("neg_pre_dout", dout4, 0);
        check("neg_pre_valid", dv4, 0);
        sync4 = 1; tick(); sync4 = 0;
        run_to(15);
        check("neg_fs_valid", dv4, 1);
        check("neg_fs_dout", dout4, -512);
        for (int k = 0; k < 4; k++) begin
            din4 = 8'(k);
            tick();
        end
        check("ramp_valid", dv4, 1);
        check("ramp_dout", dout4, 6);
        check("ramp_so", so4, 0);

        // Sync mid-window restarts the window
        restart();
        run_to(10);
        s = 0;
        for (int c = 10; c < 17; c++) begin
            sync4 = (c == 10 || c == 12);
            din4 = 8'($urandom);
            if (c >= 13 && c <= 16) s += din4;
            tick();
            if (cyc == 15) check("mid_no_strobe15", dv4, 0);
        end
        sync4 = 0;
        check("mid_v17", dv4, 1); check("mid_d17", dout4, s); check("mid_so17", so4, 1);

        // Sync on the final sample of a window
        restart();
        run_to(10);
        s = 0;
        for (int c = 10; c < 19; c++) begin
            sync4 = (c == 10 || c == 14);
            din4 = 8'($urandom);
            if (c >= 11 && c <= 14) s += din4;
            tick();
            if (cyc == 15) begin
                check("fin_v15", dv4, 1); check("fin_d15", dout4, s); check("fin_so15", so4, 0);
                s = 0;
            end
            if (c >= 15 && c <= 18) s += din4;
        end
        sync4 = 0;
        check("fin_v19", dv4, 1); check("fin_d19", dout4, s); check("fin_so19", so4, 1);

        // Reset mid-window
        restart();
        din4 = 5;
        run_to(2);
        sync4 = 1; tick(); sync4 = 0;
        run_to(7);
        check("rmw_v7", dv4, 1); check("rmw_d7", dout4, 20);
        run_to(12);
        check("rmw_hold12", dout4, 20);
        rst_n = 0;
        model_reset();
        #1;
        check("rmw_async_dout", dout4, 0);
        check("rmw_async_valid", dv4, 0);
        check("rmw_async_so", so4, 0);
        tick();
        rst_n = 1;
        run_to(20);
        sync4 = 1; tick(); sync4 = 0;
        run_to(25);
        check("rmw_v25", dv4, 1); check("rmw_d25", dout4, 20); check("rmw_so25", so4, 1);

        // Random stress on PERIOD=128
        restart();
        last_strobe = -1;
        sync_seen = 0;
        forced = 0;
        n_strobe = 0;
        for (int c = 0; c < 4000; c++) begin
            din128 = 8'($urandom);
            din4 = 8'($urandom);
            sync128 = (c == 3) || ($urandom_range(0, 699) == 0);
            if (!forced && c > 1000 && marm[1] && wcnt[1] == 127) begin
                sync128 = 1;
                forced = 1;
            end
            if (sync128) sync_seen = 1;
            tick();
            if (dv128) begin
                n_strobe++;
                if (last_strobe >= 0 && !sync_seen) check("spacing", cyc - last_strobe, 128);
                last_strobe = cyc;
                sync_seen = 0;
            end
        end
        sync128 = 0;
        check("strobe_count_ok", (n_strobe >= 20) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
